// File: rtl/heap_pkg.sv
// Shared definitions for the heap array read-out engine.
// Holds the sizing constants, the reader FSM state encoding, the element
// payload carried through the skid buffer and the area-base helper.
package heap_pkg;

  localparam int MEW     = 12;
  localparam int NArea   = 7;
  localparam int NArrays = 4;
  localparam int NHeap   = NArea * NArrays;

  typedef logic [MEW-1:0] addr_t;
  typedef logic [MEW-1:0] word_t;

  localparam word_t AREA_W   = word_t'(NArea);
  localparam word_t ARRAYS_W = word_t'(NArrays);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SIZE  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    FREE  = 3'd4,
    DONE  = 3'd5
  } reader_state_t;

  typedef struct packed {
    word_t data;
    word_t index;
    logic  last;
  } elem_t;

  // First heap word of an array area; only meaningful for a checked handle.
  function automatic addr_t area_base(input word_t handle);
    addr_t prod;
    prod = handle * AREA_W;
    return prod;
  endfunction

endpackage

// File: rtl/heap_skid_buffer.sv
// Two-entry valid/ready FIFO for streamed heap elements.
// The head entry drives the outputs directly from registers; the second
// entry absorbs a returning read while the consumer stalls.
// Ports:
//   clock, reset         clock and asynchronous active-low reset
//   in_valid/in_elem     element written this cycle (caller guarantees space)
//   out_valid/out_ready  consumer handshake
//   out_data/index/last  head element fields
//   free_slots           number of empty entries (0..2)
module heap_skid_buffer
  import heap_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  elem_t       in_elem,
  output logic        out_valid,
  input  logic        out_ready,
  output word_t       out_data,
  output word_t       out_index,
  output logic        out_last,
  output logic [1:0]  free_slots
);

  logic  hd_valid_r;
  logic  sk_valid_r;
  elem_t hd_r;
  elem_t sk_r;
  logic  pop_s;

  assign pop_s      = hd_valid_r && out_ready;
  assign out_valid  = hd_valid_r;
  assign out_data   = hd_r.data;
  assign out_index  = hd_r.index;
  assign out_last   = hd_r.last;
  assign free_slots = 2'd2 - {1'b0, hd_valid_r} - {1'b0, sk_valid_r};

  // Head/second entry update: pop shifts the second entry forward, push fills the first empty slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hd_valid_r <= 1'b0;
      sk_valid_r <= 1'b0;
      hd_r       <= '{data: {MEW{1'b0}}, index: {MEW{1'b0}}, last: 1'b0};
      sk_r       <= '{data: {MEW{1'b0}}, index: {MEW{1'b0}}, last: 1'b0};
    end else if (pop_s) begin
      if (sk_valid_r) begin
        hd_r <= sk_r;
        if (in_valid) begin
          sk_r <= in_elem;
        end else begin
          sk_valid_r <= 1'b0;
        end
      end else if (in_valid) begin
        hd_r <= in_elem;
      end else begin
        hd_valid_r <= 1'b0;
      end
    end else if (in_valid) begin
      if (!hd_valid_r) begin
        hd_r       <= in_elem;
        hd_valid_r <= 1'b1;
      end else begin
        sk_r       <= in_elem;
        sk_valid_r <= 1'b1;
      end
    end else begin
      hd_valid_r <= hd_valid_r;
    end
  end

endmodule

// File: rtl/heap_array_reader.sv
// Streams elements 0..size-1 of one heap array area over a valid/ready
// channel and optionally releases the handle afterwards.
// Ports:
//   clock, reset             clock and asynchronous active-low reset
//   req_valid/ready/array/free  request channel (ready only in IDLE)
//   sz_array/sz_data         arraySizes lookup, combinational
//   mem_rd_en/addr/data      heap read port, data one cycle after enable
//   out_valid/ready/data/index/last  element stream
//   free_valid/free_array    one-cycle release pulse
//   done/err                 one-cycle completion pulse, err for bad handle or clamp
module heap_array_reader
  import heap_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [MEW-1:0] req_array,
  input  logic           req_free,
  output logic [MEW-1:0] sz_array,
  input  logic [MEW-1:0] sz_data,
  output logic           mem_rd_en,
  output logic [MEW-1:0] mem_rd_addr,
  input  logic [MEW-1:0] mem_rd_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MEW-1:0] out_data,
  output logic [MEW-1:0] out_index,
  output logic           out_last,
  output logic           free_valid,
  output logic [MEW-1:0] free_array,
  output logic           done,
  output logic           err
);

  reader_state_t state_r, state_n;
  word_t array_r, size_r, idx_r, tag_idx_r, free_array_r;
  addr_t base_r;
  logic  free_req_r, err_flag_r, inflight_r, tag_last_r;
  logic  done_r, err_r, free_valid_r;
  logic  issue_s, pop_s, can_issue_s, last_idx_s, bad_handle_s;
  logic  [1:0] free_slots_s;
  logic  [2:0] free_eff_s;
  elem_t in_elem_s;

  assign req_ready    = (state_r == IDLE);
  assign mem_rd_en    = issue_s;
  assign free_valid   = free_valid_r;
  assign free_array   = free_array_r;
  assign done         = done_r;
  assign err          = err_r;
  assign bad_handle_s = (array_r >= ARRAYS_W);
  assign last_idx_s   = (idx_r == (size_r - word_t'(1)));
  assign pop_s        = out_valid && out_ready;
  // A slot emptied by this cycle's pop counts as free, which keeps one element per cycle flowing.
  assign free_eff_s   = {1'b0, free_slots_s} + {2'b00, pop_s};
  assign can_issue_s  = (free_eff_s > {2'b00, inflight_r});
  assign in_elem_s    = '{data: mem_rd_data, index: tag_idx_r, last: tag_last_r};

  // Next-state logic and combinational memory/size lookups.
  always_comb begin
    state_n     = state_r;
    issue_s     = 1'b0;
    sz_array    = {MEW{1'b0}};
    mem_rd_addr = {MEW{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_valid) state_n = SIZE;
        else           state_n = IDLE;
      end
      SIZE: begin
        sz_array = array_r;
        if (bad_handle_s)            state_n = DONE;
        else if (sz_data == {MEW{1'b0}}) state_n = free_req_r ? FREE : DONE;
        else                         state_n = READ;
      end
      READ: begin
        if (can_issue_s) begin
          issue_s     = 1'b1;
          mem_rd_addr = base_r + idx_r;
          state_n     = last_idx_s ? DRAIN : READ;
        end else begin
          state_n = READ;
        end
      end
      DRAIN: begin
        if (!inflight_r && (free_slots_s == 2'd2)) state_n = free_req_r ? FREE : DONE;
        else                                       state_n = DRAIN;
      end
      FREE:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, request latches, size capture and read index tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      array_r    <= {MEW{1'b0}};
      free_req_r <= 1'b0;
      size_r     <= {MEW{1'b0}};
      base_r     <= {MEW{1'b0}};
      idx_r      <= {MEW{1'b0}};
      err_flag_r <= 1'b0;
      inflight_r <= 1'b0;
      tag_idx_r  <= {MEW{1'b0}};
      tag_last_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      inflight_r <= issue_s;
      if (issue_s) begin
        idx_r      <= idx_r + word_t'(1);
        tag_idx_r  <= idx_r;
        tag_last_r <= last_idx_s;
      end
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            array_r    <= req_array;
            free_req_r <= req_free;
            err_flag_r <= 1'b0;
            idx_r      <= {MEW{1'b0}};
          end
        end
        SIZE: begin
          base_r <= area_base(array_r);
          if (bad_handle_s) begin
            err_flag_r <= 1'b1;
          end else if (sz_data > AREA_W) begin
            size_r     <= AREA_W;
            err_flag_r <= 1'b1;
          end else begin
            size_r <= sz_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered completion and release pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      free_valid_r <= 1'b0;
      free_array_r <= {MEW{1'b0}};
    end else begin
      done_r       <= (state_r == DONE);
      err_r        <= (state_r == DONE) && err_flag_r;
      free_valid_r <= (state_r == FREE);
      if (state_r == FREE) free_array_r <= array_r;
      else                 free_array_r <= free_array_r;
    end
  end

  heap_skid_buffer u_skid (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (inflight_r),
    .in_elem    (in_elem_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .free_slots (free_slots_s)
  );

endmodule

// File: tb/tb_heap_array_reader.sv
// Directed bench for heap_array_reader with a heap / arraySizes model.
module tb_heap_array_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_array = 12'd0;
  logic        req_free = 1'b0;
  logic [11:0] sz_array;
  logic [11:0] sz_data;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [11:0] mem_rd_data = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_data;
  logic [11:0] out_index;
  logic        out_last;
  logic        free_valid;
  logic [11:0] free_array;
  logic        done;
  logic        err;

  logic [11:0] heap  [0:27];
  logic [11:0] sizes [0:3];

  int total = 0;
  int bad = 0;

  int c, first_ov_c, done_c, free_c, rd_cnt, free_cnt, done_cnt, ov_cnt, stab_bad;
  logic        done_err;
  logic [11:0] free_arr_seen;
  logic        stall_pend;
  logic [11:0] stall_d, stall_i;
  logic        pat_mode = 1'b0;
  logic [15:0] pat_bits = 16'hFD53;
  logic [11:0] hs_d[$];
  logic [11:0] hs_i[$];
  logic        hs_l[$];
  int          hs_c[$];

  always #5 clock = ~clock;

  heap_array_reader dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_array(req_array), .req_free(req_free),
    .sz_array(sz_array), .sz_data(sz_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .free_valid(free_valid), .free_array(free_array),
    .done(done), .err(err)
  );

  always_comb sz_data = (sz_array < 12'd4) ? sizes[sz_array[1:0]] : 12'd0;

  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= (mem_rd_addr < 12'd28) ? heap[mem_rd_addr[4:0]] : 12'hFFF;
  end

  task automatic clear_mon();
    c = 0; first_ov_c = -1; done_c = -1; free_c = -1;
    rd_cnt = 0; free_cnt = 0; done_cnt = 0; ov_cnt = 0; stab_bad = 0;
    done_err = 1'b0; free_arr_seen = 12'd0; stall_pend = 1'b0;
    hs_d.delete(); hs_i.delete(); hs_l.delete(); hs_c.delete();
  endtask

  // Advance one cycle: drive out_ready at the falling edge, then observe.
  task automatic cyc();
    @(negedge clock);
    c++;
    if (pat_mode && c < 16) out_ready = pat_bits[c];
    else                    out_ready = 1'b1;
    #1;
    if (stall_pend && (!out_valid || out_data !== stall_d || out_index !== stall_i)) stab_bad++;
    stall_pend = out_valid && !out_ready;
    stall_d = out_data;
    stall_i = out_index;
    if (out_valid) begin
      ov_cnt++;
      if (first_ov_c < 0) first_ov_c = c;
    end
    if (out_valid && out_ready) begin
      hs_d.push_back(out_data); hs_i.push_back(out_index);
      hs_l.push_back(out_last); hs_c.push_back(c);
    end
    if (mem_rd_en) rd_cnt++;
    if (free_valid) begin free_cnt++; free_c = c; free_arr_seen = free_array; end
    if (done) begin done_cnt++; done_c = c; done_err = err; end
  endtask

  task automatic start_req(input logic [11:0] a, input logic f);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
    req_valid = 1'b1; req_array = a; req_free = f;
    cyc();
    req_valid = 1'b0; req_array = 12'd0; req_free = 1'b0;
    c = 0;
  endtask

  task automatic run_until_done(input int maxc);
    while (done_cnt == 0 && c < maxc) cyc();
    repeat (2) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; #2; reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({req_ready, mem_rd_en, out_valid, out_last, free_valid, done, err} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 1000000",
               {req_ready, mem_rd_en, out_valid, out_last, free_valid, done, err});
    end
    total++;
    if ({out_data, out_index, mem_rd_addr, free_array, sz_array} !== 60'd0) begin
      bad++;
      $display("FAIL reset_buses: got %h want 0", {out_data, out_index, mem_rd_addr, free_array, sz_array});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [24:0] got, exp;
    clear_mon(); pat_mode = 1'b0;
    start_req(12'd1, 1'b0);
    run_until_done(40);
    total++;
    if (first_ov_c != 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", first_ov_c); end
    total++;
    if (hs_d.size() != 3) begin bad++; $display("FAIL basic_count: got %0d want 3", hs_d.size()); end
    for (int i = 0; i < 3 && i < hs_d.size(); i++) begin
      got = {hs_d[i], hs_i[i], hs_l[i]};
      exp = {12'(5 + i), 12'(i), (i == 2)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL basic_elem%0d: got %h want %h", i, got, exp); end
      total++;
      if (hs_c[i] != 3 + i) begin bad++; $display("FAIL basic_cycle%0d: got %0d want %0d", i, hs_c[i], 3 + i); end
    end
    total++;
    if (done_cnt != 1 || done_err !== 1'b0) begin
      bad++; $display("FAIL basic_done: got done=%0d err=%b want 1/0", done_cnt, done_err);
    end
    total++;
    if (rd_cnt != 3 || free_cnt != 0) begin
      bad++; $display("FAIL basic_reads: got rd=%0d free=%0d want 3/0", rd_cnt, free_cnt);
    end
  endtask

  task automatic test_stall();
    logic [24:0] got, exp;
    clear_mon();
    start_req(12'd1, 1'b0);
    pat_mode = 1'b1;
    run_until_done(60);
    pat_mode = 1'b0;
    total++;
    if (hs_d.size() != 3) begin bad++; $display("FAIL stall_count: got %0d want 3", hs_d.size()); end
    for (int i = 0; i < 3 && i < hs_d.size(); i++) begin
      got = {hs_d[i], hs_i[i], hs_l[i]};
      exp = {12'(5 + i), 12'(i), (i == 2)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL stall_elem%0d: got %h want %h", i, got, exp); end
    end
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stab_bad); end
    total++;
    if (done_cnt != 1 || done_err !== 1'b0 || rd_cnt != 3) begin
      bad++; $display("FAIL stall_done: got done=%0d err=%b rd=%0d want 1/0/3", done_cnt, done_err, rd_cnt);
    end
  endtask

  task automatic test_empty_free();
    clear_mon();
    start_req(12'd2, 1'b1);
    run_until_done(20);
    total++;
    if (ov_cnt != 0 || rd_cnt != 0) begin
      bad++; $display("FAIL empty_stream: got ov=%0d rd=%0d want 0/0", ov_cnt, rd_cnt);
    end
    total++;
    if (free_cnt != 1 || free_arr_seen !== 12'd2) begin
      bad++; $display("FAIL empty_free: got n=%0d arr=%0d want 1/2", free_cnt, free_arr_seen);
    end
    total++;
    if (done_cnt != 1 || done_err !== 1'b0 || !(free_c < done_c)) begin
      bad++; $display("FAIL empty_done: got done=%0d err=%b free_c=%0d done_c=%0d want 1/0/free first",
                      done_cnt, done_err, free_c, done_c);
    end
  endtask

  task automatic test_bad_handle();
    clear_mon();
    start_req(12'd5, 1'b1);
    run_until_done(20);
    total++;
    if (rd_cnt != 0 || free_cnt != 0) begin
      bad++; $display("FAIL badh_access: got rd=%0d free=%0d want 0/0", rd_cnt, free_cnt);
    end
    total++;
    if (done_cnt != 1 || done_err !== 1'b1 || done_c != 2) begin
      bad++; $display("FAIL badh_done: got done=%0d err=%b cyc=%0d want 1/1/2", done_cnt, done_err, done_c);
    end
  endtask

  task automatic test_clamp();
    logic [24:0] got, exp;
    clear_mon();
    start_req(12'd0, 1'b0);
    run_until_done(60);
    total++;
    if (hs_d.size() != 7) begin bad++; $display("FAIL clamp_count: got %0d want 7", hs_d.size()); end
    for (int i = 0; i < 7 && i < hs_d.size(); i++) begin
      got = {hs_d[i], hs_i[i], hs_l[i]};
      exp = {12'(100 + i), 12'(i), (i == 6)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL clamp_elem%0d: got %h want %h", i, got, exp); end
    end
    total++;
    if (done_cnt != 1 || done_err !== 1'b1) begin
      bad++; $display("FAIL clamp_err: got done=%0d err=%b want 1/1", done_cnt, done_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] got, exp;
    clear_mon();
    start_req(12'd1, 1'b0);
    while (hs_d.size() < 2 && c < 30) cyc();
    total++;
    if (hs_d.size() != 2) begin bad++; $display("FAIL rmid_progress: got %0d want 2", hs_d.size()); end
    cyc();
    reset = 1'b0;
    #1;
    total++;
    if ({req_ready, mem_rd_en, out_valid, out_last, free_valid, done, err} !== 7'b1000000 ||
        {out_data, out_index, mem_rd_addr, free_array, sz_array} !== 60'd0) begin
      bad++; $display("FAIL rmid_outputs: got %b/%h want 1000000/0",
                      {req_ready, mem_rd_en, out_valid, out_last, free_valid, done, err},
                      {out_data, out_index, mem_rd_addr, free_array, sz_array});
    end
    clear_mon();
    repeat (2) cyc();
    reset = 1'b1;
    repeat (2) cyc();
    total++;
    if (done_cnt != 0 || free_cnt != 0 || ov_cnt != 0) begin
      bad++; $display("FAIL rmid_quiet: got done=%0d free=%0d ov=%0d want 0/0/0", done_cnt, free_cnt, ov_cnt);
    end
    clear_mon();
    start_req(12'd1, 1'b0);
    run_until_done(40);
    total++;
    if (hs_d.size() != 3) begin bad++; $display("FAIL rmid_count: got %0d want 3", hs_d.size()); end
    for (int i = 0; i < 3 && i < hs_d.size(); i++) begin
      got = {hs_d[i], hs_i[i], hs_l[i]};
      exp = {12'(5 + i), 12'(i), (i == 2)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL rmid_elem%0d: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 28; i++) heap[i] = 12'(100 + i);
    heap[7] = 12'd5; heap[8] = 12'd6; heap[9] = 12'd7;
    sizes[0] = 12'd9; sizes[1] = 12'd3; sizes[2] = 12'd0; sizes[3] = 12'd2;
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_empty_free();
    test_bad_handle();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
